// File: rtl/swipe_pkg.sv
// swipe_pkg: tracker state encodings and zone/band threshold helpers shared by
// the swipe gesture recogniser.
package swipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CENTER = 3'd1,
        ST_OUT    = 3'd2,
        ST_BACK   = 3'd3,
        ST_DONE   = 3'd4
    } trk_state_e;

    function automatic int zone_threshold(input int max_x, input int zones, input int k);
        return k * (max_x + 1) / zones;
    endfunction

    function automatic int band_threshold(input int max_y);
        return 2 * max_y / 3;
    endfunction

endpackage

// File: rtl/swipe_hand_tracker.sv
// swipe_hand_tracker: follows one hand from the centre zone outward SPAN zones
// and back; DIR=+1 walks toward higher zones, DIR=-1 toward lower zones.
module swipe_hand_tracker
    import swipe_pkg::*;
#(
    parameter int ZONES   = 5,
    parameter int SPAN    = 2,
    parameter int TIMEOUT = 30,
    parameter int DIR     = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     upd,
    input  logic                     clear,
    input  logic [$clog2(ZONES)-1:0] zone,
    input  logic                     in_band,
    output trk_state_e               state
);

    localparam int C  = ZONES / 2;
    localparam int ZW = $clog2(ZONES);
    localparam int DW = $clog2(SPAN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [DW-1:0] depth;
    logic [TW-1:0] timer;
    logic [ZW-1:0] cur_z;
    logic [ZW-1:0] adv_z;
    logic          expired;
    logic          progress;

    assign cur_z    = ZW'(C + DIR * int'(depth));
    assign adv_z    = ZW'(C + DIR * (state == ST_BACK ? int'(depth) - 1 : int'(depth) + 1));
    assign expired  = timer == TW'(TIMEOUT - 1);
    assign progress = in_band && (zone == cur_z || zone == adv_z);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n || clear) begin
            state <= ST_IDLE;
            depth <= '0;
            timer <= '0;
        end else if (upd) begin
            case (state)
                ST_IDLE: begin
                    if (in_band && zone == ZW'(C)) state <= ST_CENTER;
                end
                ST_DONE: begin
                    if (expired) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (!progress) begin
                        if (expired) begin
                            state <= ST_IDLE;
                            depth <= '0;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else begin
                        timer <= '0;
                        if (zone == adv_z) begin
                            if (state == ST_BACK) begin
                                depth <= depth - 1'b1;
                                if (depth == DW'(1)) state <= ST_DONE;
                            end else begin
                                depth <= depth + 1'b1;
                                state <= (int'(depth) + 1 == SPAN) ? ST_BACK : ST_OUT;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/swipe_gesture_fsm.sv
// swipe_gesture_fsm: two-hand swipe-out-and-back recogniser; zone stage, two
// hand trackers, and the completion pulse register.
module swipe_gesture_fsm
    import swipe_pkg::*;
#(
    parameter int MAX_X        = 1023,
    parameter int MAX_Y        = 767,
    parameter int COORD_W      = 16,
    parameter int ZONES        = 5,
    parameter int SPAN         = 2,
    parameter int TIMEOUT      = 30,
    parameter int REQUIRE_BOTH = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic               gesture_pulse,
    output logic [1:0]         gesture_id,
    output logic [2:0]         state_left,
    output logic [2:0]         state_right,
    output logic               busy
);

    localparam int ZW = $clog2(ZONES);
    localparam logic [COORD_W-1:0] BAND = COORD_W'(band_threshold(MAX_Y));

    function automatic logic [ZW-1:0] zone_of(input logic [COORD_W-1:0] x);
        logic [ZW-1:0] z;
        z = '0;
        for (int k = 1; k < ZONES; k++)
            if (x >= COORD_W'(zone_threshold(MAX_X, ZONES, k))) z = z + 1'b1;
        return z;
    endfunction

    logic          zv;
    logic [ZW-1:0] zl;
    logic [ZW-1:0] zr;
    logic          bl;
    logic          br;
    trk_state_e    st_l;
    trk_state_e    st_r;
    logic          dl;
    logic          dr;
    logic          fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zv <= 1'b0;
            zl <= '0;
            zr <= '0;
            bl <= 1'b0;
            br <= 1'b0;
        end else begin
            zv <= sample_valid;
            if (sample_valid) begin
                zl <= zone_of(x1);
                zr <= zone_of(x2);
                bl <= y1 > BAND;
                br <= y2 > BAND;
            end
        end
    end

    swipe_hand_tracker #(.ZONES(ZONES), .SPAN(SPAN), .TIMEOUT(TIMEOUT), .DIR(-1)) u_left (
        .clock(clock), .reset_n(reset_n), .upd(zv), .clear(fire),
        .zone(zl), .in_band(bl), .state(st_l)
    );

    swipe_hand_tracker #(.ZONES(ZONES), .SPAN(SPAN), .TIMEOUT(TIMEOUT), .DIR(1)) u_right (
        .clock(clock), .reset_n(reset_n), .upd(zv), .clear(fire),
        .zone(zr), .in_band(br), .state(st_r)
    );

    assign dl   = st_l == ST_DONE;
    assign dr   = st_r == ST_DONE;
    // Firing also clears both trackers on the same edge the pulse is registered.
    assign fire = (REQUIRE_BOTH != 0) ? (dl && dr) : (dl || dr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gesture_pulse <= 1'b0;
            gesture_id    <= 2'b00;
        end else begin
            gesture_pulse <= fire;
            if (fire) gesture_id <= {dr, dl};
        end
    end

    assign state_left  = st_l;
    assign state_right = st_r;
    assign busy        = st_l != ST_IDLE || st_r != ST_IDLE;

endmodule
